// File: rtl/dob_store_if.sv
// Store-side data-bus master: takes a right-justified store from control and
// drives one lane-steered write onto the external data-out bus.
module dob_store_if #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        st_req,
    input  logic [1:0]  st_size,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    output logic        st_busy,
    output logic        st_done,
    output logic        st_err,
    output logic [31:0] dab,
    output logic [31:0] dob,
    output logic [3:0]  dbe,
    output logic        dreq,
    output logic        dwr,
    input  logic        dack,
    output logic [1:0]  dbg_state
);

    // Bus handshake: dreq/dwr rise the cycle after a store is accepted and stay
    // high with dab/dob/dbe frozen until dack is seen high at a clock edge (the
    // transfer completes on that edge) or the wait budget runs out. Control
    // side: st_req is only looked at while st_busy is low.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

    state_t      state, state_nxt;
    logic [7:0]  wait_cnt, wait_cnt_nxt;
    logic        legal;
    logic        accept;
    logic [31:0] dob_steer;
    logic [3:0]  dbe_steer;

    assign dbg_state = state;

    // Alignment check and lane steering, evaluated on the incoming request.
    always_comb begin
        legal     = 1'b0;
        dob_steer = st_data;
        dbe_steer = 4'b0000;
        case (st_size)
            2'b00: begin
                legal     = 1'b1;
                dob_steer = {4{st_data[7:0]}};
                dbe_steer = 4'b0001 << st_addr[1:0];
            end
            2'b01: begin
                legal     = ~st_addr[0];
                dob_steer = {2{st_data[15:0]}};
                dbe_steer = st_addr[1] ? 4'b1100 : 4'b0011;
            end
            2'b10: begin
                legal     = (st_addr[1:0] == 2'b00);
                dob_steer = st_data;
                dbe_steer = 4'b1111;
            end
            default: begin
                legal     = 1'b0;
                dob_steer = st_data;
                dbe_steer = 4'b0000;
            end
        endcase
    end

    assign accept = (state == S_IDLE) && st_req && legal;

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        case (state)
            S_IDLE: begin
                if (st_req) begin
                    state_nxt    = legal ? S_REQ : S_ERR;
                    wait_cnt_nxt = 8'd0;
                end
            end
            S_REQ: begin
                // An ack on the final wait cycle still completes the write.
                if (dack) begin
                    state_nxt = S_DONE;
                end else if (wait_cnt == LAST_WAIT) begin
                    state_nxt = S_ERR;
                end else begin
                    wait_cnt_nxt = wait_cnt + 8'd1;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            S_ERR:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            wait_cnt <= 8'd0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_busy <= 1'b0;
            st_done <= 1'b0;
            st_err  <= 1'b0;
            dreq    <= 1'b0;
            dwr     <= 1'b0;
            dab     <= 32'd0;
            dob     <= 32'd0;
            dbe     <= 4'd0;
        end else begin
            st_busy <= (state_nxt != S_IDLE);
            st_done <= (state_nxt == S_DONE);
            st_err  <= (state_nxt == S_ERR);
            dreq    <= (state_nxt == S_REQ);
            dwr     <= (state_nxt == S_REQ);
            if (accept) begin
                dab <= {st_addr[31:2], 2'b00};
                dob <= dob_steer;
                dbe <= dbe_steer;
            end else if (state_nxt != S_REQ) begin
                dbe <= 4'd0;
            end
        end
    end

endmodule

// File: tb/tb_dob_store_if.sv
// Directed bench for dob_store_if: a transaction-level reference model checked
// every cycle, plus literal expectations from hand-worked store scenarios.
module tb_dob_store_if;

    localparam int TIMEOUT = 15;

    logic        clk;
    logic        rst_n;
    logic        st_req;
    logic [1:0]  st_size;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        st_busy;
    logic        st_done;
    logic        st_err;
    logic [31:0] dab;
    logic [31:0] dob;
    logic [3:0]  dbe;
    logic        dreq;
    logic        dwr;
    logic        dack;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;

    dob_store_if #(.TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .st_req    (st_req),
        .st_size   (st_size),
        .st_addr   (st_addr),
        .st_data   (st_data),
        .st_busy   (st_busy),
        .st_done   (st_done),
        .st_err    (st_err),
        .dab       (dab),
        .dob       (dob),
        .dbe       (dbe),
        .dreq      (dreq),
        .dwr       (dwr),
        .dack      (dack),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: actual=still running required=finished");
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference model ----------------
    // A store is "in flight" while waiting for ack; it ends after an ack or
    // after TIMEOUT bus cycles. Completion/error show as one-cycle pulses.
    logic        m_inflight;
    int          m_waited;
    logic        m_done;
    logic        m_err;
    logic [31:0] m_dab;
    logic [31:0] m_dob;
    logic [3:0]  m_dbe;

    function automatic logic is_legal(input logic [1:0] sz, input logic [31:0] a);
        int bytes;
        if (sz == 2'b11) return 1'b0;
        bytes = 1 << sz;
        return (a % bytes) == 0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_inflight <= 1'b0;
            m_waited   <= 0;
            m_done     <= 1'b0;
            m_err      <= 1'b0;
            m_dab      <= 32'd0;
            m_dob      <= 32'd0;
            m_dbe      <= 4'd0;
        end else begin
            m_done <= 1'b0;
            m_err  <= 1'b0;
            if (m_inflight) begin
                if (dack) begin
                    m_inflight <= 1'b0;
                    m_done     <= 1'b1;
                    m_dbe      <= 4'd0;
                end else if (m_waited + 1 >= TIMEOUT) begin
                    m_inflight <= 1'b0;
                    m_err      <= 1'b1;
                    m_dbe      <= 4'd0;
                end else begin
                    m_waited <= m_waited + 1;
                end
            end else if (!m_done && !m_err && st_req) begin
                if (is_legal(st_size, st_addr)) begin
                    m_inflight <= 1'b1;
                    m_waited   <= 0;
                    m_dab      <= st_addr - (st_addr % 4);
                    case (st_size)
                        2'b00: begin
                            m_dob <= (st_data & 32'hFF) * 32'h01010101;
                            m_dbe <= 4'(1 << (st_addr % 4));
                        end
                        2'b01: begin
                            m_dob <= (st_data & 32'hFFFF) * 32'h00010001;
                            m_dbe <= 4'(3 << (st_addr % 4));
                        end
                        default: begin
                            m_dob <= st_data;
                            m_dbe <= 4'hF;
                        end
                    endcase
                end else begin
                    m_err <= 1'b1;
                end
            end
        end
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model; expected values for the bus
    // fields are queued only while a transfer is outstanding.
    logic [31:0] exp_q[$];
    always @(negedge clk) begin
        check("m_busy", 32'(st_busy), 32'(m_inflight | m_done | m_err));
        check("m_done", 32'(st_done), 32'(m_done));
        check("m_err",  32'(st_err),  32'(m_err));
        check("m_dreq", 32'(dreq),    32'(m_inflight));
        check("m_dwr",  32'(dwr),     32'(m_inflight));
        check("m_dbe",  32'(dbe),     32'(m_dbe));
        if (m_inflight) begin
            exp_q.push_back(m_dab);
            exp_q.push_back(m_dob);
            check("m_dab", dab, exp_q.pop_front());
            check("m_dob", dob, exp_q.pop_front());
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
        st_req  = 1'b1;
        st_size = sz;
        st_addr = a;
        st_data = d;
        tick();
        st_req  = 1'b0;
    endtask

    task automatic ack_now();
        dack = 1'b1;
        tick();
        dack = 1'b0;
    endtask

    // ---------------- directed stimulus ----------------
    int n;

    initial begin
        rst_n   = 1'b0;
        st_req  = 1'b0;
        st_size = 2'b00;
        st_addr = 32'd0;
        st_data = 32'd0;
        dack    = 1'b0;
        repeat (2) tick();
        check("rst_busy", 32'(st_busy), 32'd0);
        check("rst_dreq", 32'(dreq), 32'd0);
        check("rst_dbe",  32'(dbe), 32'd0);
        check("rst_dab",  dab, 32'd0);
        rst_n = 1'b1;
        tick();

        // 1: byte store to lane 3, ack two cycles after the request
        start_store(2'b00, 32'h0000_1003, 32'hAAAA_AAAA);
        check("t1_dreq", 32'(dreq), 32'd1);
        check("t1_dab",  dab, 32'h0000_1000);
        check("t1_dbe",  32'(dbe), 32'h8);
        check("t1_dob",  dob, 32'hAAAA_AAAA);
        tick();
        ack_now();
        check("t1_done", 32'(st_done), 32'd1);
        check("t1_dreq_drop", 32'(dreq), 32'd0);
        tick();
        check("t1_idle", 32'(st_busy), 32'd0);

        // 2: upper halfword, then misaligned halfword
        start_store(2'b01, 32'h0000_2002, 32'h0000_BBBB);
        check("t2_dbe", 32'(dbe), 32'hC);
        check("t2_dob", dob, 32'hBBBB_BBBB);
        ack_now();
        check("t2_done", 32'(st_done), 32'd1);
        tick();
        start_store(2'b01, 32'h0000_2001, 32'h0000_1234);
        check("t2_mis_err",  32'(st_err), 32'd1);
        check("t2_mis_dreq", 32'(dreq), 32'd0);
        tick();

        // 3: word store that is never acknowledged
        start_store(2'b10, 32'h0000_3000, 32'hCCCC_CCCC);
        n = 0;
        while (dreq && n < 100) begin
            n++;
            tick();
        end
        check("t3_req_cycles", 32'(n), 32'(TIMEOUT));
        check("t3_err", 32'(st_err), 32'd1);
        tick();
        check("t3_idle", 32'(st_busy), 32'd0);

        // 4: reserved size, stray ack, request during an active transfer
        start_store(2'b11, 32'h0000_0000, 32'h1111_1111);
        check("t4_rsv_err", 32'(st_err), 32'd1);
        tick();
        dack = 1'b1;
        tick();
        check("t4_stray_done", 32'(st_done), 32'd0);
        tick();
        dack = 1'b0;
        check("t4_stray_busy", 32'(st_busy), 32'd0);
        start_store(2'b10, 32'h0000_4000, 32'h1234_5678);
        st_req  = 1'b1;
        st_size = 2'b00;
        st_addr = 32'h0000_5001;
        repeat (2) tick();
        st_req  = 1'b0;
        check("t4_hold_dab", dab, 32'h0000_4000);
        check("t4_hold_dob", dob, 32'h1234_5678);
        ack_now();
        check("t4_done", 32'(st_done), 32'd1);
        tick();
        check("t4_no_second", 32'(st_busy), 32'd0);

        // 5: asynchronous reset while the bus request is up
        start_store(2'b10, 32'h0000_6000, 32'h0BAD_F00D);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_dreq", 32'(dreq), 32'd0);
        check("t5_dwr",  32'(dwr), 32'd0);
        check("t5_busy", 32'(st_busy), 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        start_store(2'b00, 32'h0000_6001, 32'h0000_0055);
        check("t5_dbe", 32'(dbe), 32'h2);
        check("t5_dob", dob, 32'h5555_5555);
        ack_now();
        check("t5_done", 32'(st_done), 32'd1);
        tick();

        // 6: back-to-back stores, second acked on its last allowed cycle
        start_store(2'b10, 32'h0000_7000, 32'hDEAD_BEEF);
        ack_now();
        check("t6_done_a", 32'(st_done), 32'd1);
        tick();
        start_store(2'b10, 32'h0000_7004, 32'hFEED_FACE);
        check("t6_dreq_b", 32'(dreq), 32'd1);
        check("t6_dab_b",  dab, 32'h0000_7004);
        repeat (TIMEOUT - 1) tick();
        check("t6_still_req", 32'(dreq), 32'd1);
        ack_now();
        check("t6_done_b", 32'(st_done), 32'd1);
        check("t6_no_err", 32'(st_err), 32'd0);
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
